// File: rtl/matrix_stream_transpose_if.sv
// Row-stream handshake bundle: row-serial input side and transposed-row output side.
interface matrix_stream_transpose_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned D     = 3,
  parameter int unsigned WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [D-1:0][WIDTH-1:0] in_row;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [N-1:0][WIDTH-1:0] out_row;

  // slave: the transpose block; master: the surrounding producer/consumer
  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_last
  );
  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/matrix_stream_transpose.sv
// Buffers an N x D matrix arriving one row per handshake, then emits its
// D x N transpose one row (= one input column) per handshake.
module matrix_stream_transpose #(
  parameter int unsigned N     = 3,
  parameter int unsigned D     = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  matrix_stream_transpose_if.slave   s,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EMIT = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [RW-1:0]           row_cnt_q, row_cnt_d;
  logic [CW-1:0]           col_cnt_q, col_cnt_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        buf_q [N][D];

  logic                    in_ready_c, out_valid_c, out_last_c, busy_c;
  logic [N-1:0][WIDTH-1:0] out_row_c;
  logic                    accept, handshake;

  assign accept    = s.in_valid & in_ready_c;
  assign handshake = out_valid_c & s.out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      done_q    <= done_d;
    end
  end

  // Matrix buffer; rows are selected by constant compare to keep indices exact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++)
        for (int j = 0; j < int'(D); j++)
          buf_q[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < int'(N); i++)
        if (row_cnt_q == RW'(i))
          for (int j = 0; j < int'(D); j++)
            buf_q[i][j] <= s.in_row[j];
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (row_cnt_q == RW'(N - 1)) begin
            row_cnt_d = '0;
            state_d   = EMIT;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          if (out_last_c) begin
            col_cnt_d = '0;
            state_d   = LOAD;
            done_d    = 1'b1;
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
      end
      EMIT: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
      end
      default: ;
    endcase
  end

  // Column mux; forced to zero outside EMIT
  always_comb begin
    out_row_c  = '0;
    out_last_c = out_valid_c & (col_cnt_q == CW'(D - 1));
    if (out_valid_c) begin
      for (int i = 0; i < int'(N); i++)
        for (int j = 0; j < int'(D); j++)
          if (col_cnt_q == CW'(j))
            out_row_c[i] = buf_q[i][j];
    end
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_c;
  assign s.out_last  = out_last_c;
  assign s.out_row   = out_row_c;
  assign busy_o      = busy_c;
  assign done_o      = done_q;

endmodule

// File: tb/tb_matrix_stream_transpose.sv
// Randomized bench for matrix_stream_transpose: three geometries (3x3, 2x4, 1x1)
// checked cycle by cycle against a queue-based transpose model.
module tb_matrix_stream_transpose;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_stream_transpose_if #(.N(3), .D(3), .WIDTH(8)) bus0 ();
  matrix_stream_transpose_if #(.N(2), .D(4), .WIDTH(8)) bus1 ();
  matrix_stream_transpose_if #(.N(1), .D(1), .WIDTH(8)) bus2 ();
  logic busy0, done0, busy1, done1, busy2, done2;

  matrix_stream_transpose #(.N(3), .D(3), .WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .s(bus0), .busy_o(busy0), .done_o(done0));
  matrix_stream_transpose #(.N(2), .D(4), .WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .s(bus1), .busy_o(busy1), .done_o(done1));
  matrix_stream_transpose #(.N(1), .D(1), .WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .s(bus2), .busy_o(busy2), .done_o(done2));

  typedef struct {
    int in_ready;
    int out_valid;
    int out_last;
    int busy;
    int done;
    int row [4];
  } obs_t;

  int src_q[$];
  bit rpat_q[$];

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic obs_t sample(input int cfg);
    obs_t o;
    for (int i = 0; i < 4; i++) o.row[i] = 0;
    case (cfg)
      0: begin
        o.in_ready = int'(bus0.in_ready); o.out_valid = int'(bus0.out_valid);
        o.out_last = int'(bus0.out_last); o.busy = int'(busy0); o.done = int'(done0);
        for (int i = 0; i < 3; i++) o.row[i] = int'($signed(bus0.out_row[i]));
      end
      1: begin
        o.in_ready = int'(bus1.in_ready); o.out_valid = int'(bus1.out_valid);
        o.out_last = int'(bus1.out_last); o.busy = int'(busy1); o.done = int'(done1);
        for (int i = 0; i < 2; i++) o.row[i] = int'($signed(bus1.out_row[i]));
      end
      default: begin
        o.in_ready = int'(bus2.in_ready); o.out_valid = int'(bus2.out_valid);
        o.out_last = int'(bus2.out_last); o.busy = int'(busy2); o.done = int'(done2);
        o.row[0] = int'($signed(bus2.out_row[0]));
      end
    endcase
    return o;
  endfunction

  task automatic drive(input int cfg, input logic v, input int row [4], input logic rdy);
    case (cfg)
      0: begin
        bus0.in_valid = v; bus0.out_ready = rdy;
        for (int j = 0; j < 3; j++) bus0.in_row[j] = 8'(row[j]);
      end
      1: begin
        bus1.in_valid = v; bus1.out_ready = rdy;
        for (int j = 0; j < 4; j++) bus1.in_row[j] = 8'(row[j]);
      end
      default: begin
        bus2.in_valid = v; bus2.out_ready = rdy;
        bus2.in_row[0] = 8'(row[0]);
      end
    endcase
  endtask

  task automatic do_reset();
    obs_t o;
    int z [4];
    for (int j = 0; j < 4; j++) z[j] = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) drive(c, 1'b0, z, 1'b0);
    #1;
    for (int c = 0; c < 3; c++) begin
      o = sample(c);
      check_eq($sformatf("c%0d rst in_ready", c), o.in_ready, 0);
      check_eq($sformatf("c%0d rst out_valid", c), o.out_valid, 0);
      check_eq($sformatf("c%0d rst out_last", c), o.out_last, 0);
      check_eq($sformatf("c%0d rst busy", c), o.busy, 0);
      check_eq($sformatf("c%0d rst done", c), o.done, 0);
      check_eq($sformatf("c%0d rst out_row0", c), o.row[0], 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams nmat matrices from src_q (random if empty); called at a negedge.
  task automatic run_mats(input int cfg, input int n, input int d, input int nmat,
                          input int vpct, input int rpct, input int abort_after,
                          input bit idle0);
    obs_t o;
    int   cur[$];
    int   exp_out[$];
    int   row [4];
    int   pos, emitted, accepts, cyc, budget;
    bit   idle, done_exp, exp_ir, exp_ov, acc, hs, aborted;
    logic v, rdy;
    if (src_q.size() == 0)
      for (int k = 0; k < nmat * n * d; k++) src_q.push_back($urandom_range(0, 255) - 128);
    idle = idle0; done_exp = 1'b0; aborted = 1'b0;
    pos = 0; emitted = 0; accepts = 0; cyc = 0;
    budget = 40 * nmat * (n + d) + 50;
    while ((emitted < nmat * d || done_exp) && !aborted) begin
      if (cyc++ > budget) begin
        check_eq($sformatf("c%0d timeout", cfg), emitted, nmat * d);
        break;
      end
      o = sample(cfg);
      exp_ir = !idle && (exp_out.size() == 0);
      exp_ov = (exp_out.size() > 0);
      check_eq($sformatf("c%0d in_ready", cfg), o.in_ready, int'(exp_ir));
      check_eq($sformatf("c%0d out_valid", cfg), o.out_valid, int'(exp_ov));
      check_eq($sformatf("c%0d busy", cfg), o.busy, int'(!idle));
      check_eq($sformatf("c%0d done", cfg), o.done, int'(done_exp));
      check_eq($sformatf("c%0d out_last", cfg), o.out_last,
               int'(exp_ov && exp_out.size() == n));
      for (int i = 0; i < n; i++)
        check_eq($sformatf("c%0d out_row[%0d]", cfg, i), o.row[i], exp_ov ? exp_out[i] : 0);

      v = (pos < src_q.size()) && (int'($urandom_range(0, 99)) < vpct);
      if (exp_ov && rpat_q.size() > 0) rdy = rpat_q.pop_front();
      else rdy = (int'($urandom_range(0, 99)) < rpct);
      for (int j = 0; j < 4; j++)
        row[j] = (j < d && pos + j < src_q.size()) ? src_q[pos + j]
                                                   : $urandom_range(0, 255) - 128;
      drive(cfg, v, row, rdy);
      acc = v && exp_ir;
      hs  = exp_ov && rdy;

      @(posedge clk);
      idle = 1'b0;
      done_exp = 1'b0;
      if (acc) begin
        for (int j = 0; j < d; j++) cur.push_back(row[j]);
        pos += d;
        accepts++;
        if (cur.size() == n * d) begin
          for (int c = 0; c < d; c++)
            for (int r = 0; r < n; r++) exp_out.push_back(cur[r * d + c]);
          cur.delete();
        end
        if (abort_after > 0 && accepts == abort_after) aborted = 1'b1;
      end
      if (hs) begin
        for (int i = 0; i < n; i++) void'(exp_out.pop_front());
        emitted++;
        if (exp_out.size() == 0) done_exp = 1'b1;
      end
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) row[j] = 0;
    drive(cfg, 1'b0, row, 1'b0);
    if (!aborted) begin
      o = sample(cfg);
      check_eq($sformatf("c%0d done falls", cfg), o.done, 0);
      check_eq($sformatf("c%0d ready after", cfg), o.in_ready, 1);
    end
    src_q.delete();
    rpat_q.delete();
  endtask

  initial begin
    int z [4];
    for (int j = 0; j < 4; j++) z[j] = 0;
    for (int c = 0; c < 3; c++) drive(c, 1'b0, z, 1'b0);
    do_reset();

    // 3x3 counting matrix, back-to-back, consumer always ready
    for (int k = 1; k <= 9; k++) src_q.push_back(k);
    run_mats(0, 3, 3, 1, 100, 100, 0, 1'b1);

    // same matrix with out_ready stalls 1,0,0,1,0,1
    for (int k = 1; k <= 9; k++) src_q.push_back(k);
    rpat_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_mats(0, 3, 3, 1, 100, 0, 0, 1'b0);

    // 2x4 extreme values with input bubbles
    src_q = {-128, 127, -1, 0, 5, -6, 7, -8};
    run_mats(1, 2, 4, 1, 50, 100, 0, 1'b0);

    // reset after two of three rows, then a fresh matrix
    run_mats(0, 3, 3, 1, 100, 100, 2, 1'b0);
    do_reset();
    run_mats(0, 3, 3, 1, 100, 100, 0, 1'b1);

    // two matrices back to back, producer keeps in_valid high through EMIT
    run_mats(0, 3, 3, 2, 100, 100, 0, 1'b0);
    run_mats(0, 3, 3, 4, 70, 60, 0, 1'b0);

    // 1x1 geometry
    src_q = {42};
    run_mats(2, 1, 1, 1, 100, 100, 0, 1'b0);
    run_mats(2, 1, 1, 5, 60, 50, 0, 1'b0);

    // 2x4 random traffic
    run_mats(1, 2, 4, 4, 65, 55, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
